// File: rtl/dht_pkg.sv
// Shared types and constants for the DHT reading to UART reporter.
package dht_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        LOAD,
        SEND
    } state_t;

    localparam logic [7:0] ASC_H  = 8'h48;
    localparam logic [7:0] ASC_T  = 8'h54;
    localparam logic [7:0] ASC_EQ = 8'h3D;
    localparam logic [7:0] ASC_SP = 8'h20;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_0  = 8'h30;

    localparam int FRAME_LEN = 13;

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return ASC_0 | {4'b0000, d};
    endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter, LSB first; done pulses one cycle after the stop bit.
module uart_tx_8n1 #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready,
    output logic       done
);
    localparam logic [15:0] LAST_CLK = 16'(CLKS_PER_BIT - 1);

    logic        active;
    logic [15:0] clk_cnt;
    logic [3:0]  bit_idx;
    logic [8:0]  shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            active  <= 1'b0;
            tx      <= 1'b1;
            done    <= 1'b0;
            clk_cnt <= '0;
            bit_idx <= '0;
        end else begin
            done <= 1'b0;
            if (!active) begin
                if (start) begin
                    active  <= 1'b1;
                    tx      <= 1'b0;
                    clk_cnt <= '0;
                    bit_idx <= '0;
                end
            end else if (clk_cnt == LAST_CLK) begin
                clk_cnt <= '0;
                if (bit_idx == 4'd9) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    tx      <= shift[0];
                end
            end else begin
                clk_cnt <= clk_cnt + 16'd1;
            end
        end
    end

    // The top bit of the shifter is the stop bit; ones fill in behind it.
    always_ff @(posedge clk) begin
        if (!active && start) begin
            shift <= {1'b1, data};
        end else if (active && (clk_cnt == LAST_CLK)) begin
            shift <= {1'b1, shift[8:1]};
        end
    end

    assign ready = !active;

endmodule

// File: rtl/dht_uart_reporter.sv
// Captures new humidity/temperature readings and reports them as "H=hhh T=ttt\r\n" over UART.
module dht_uart_reporter
    import dht_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] humidity,
    input  logic [7:0] temperature,
    input  logic       valid,
    output logic       tx,
    output logic       busy,
    output logic       pending,
    output logic [7:0] drop_count
);
    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t      state, state_nx;
    logic        valid_q, captured;
    logic [15:0] last_pair;
    logic        vld_p0;
    logic [15:0] pair_p0;
    logic [15:0] slot, frame_pair;
    logic [7:0]  rem;
    logic        conv_temp;
    logic [3:0]  hun, ten;
    logic [11:0] hum_bcd, tmp_bcd;
    logic [3:0]  idx;
    logic [7:0]  tx_byte;
    logic        tx_start, tx_ready, tx_done;
    logic        new_sample, take_slot, take_new, to_slot, conv_last;

    assign new_sample = valid && (!valid_q || !captured || ({humidity, temperature} != last_pair));

    // Stage p0: registered new-sample detect
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            captured  <= 1'b0;
            last_pair <= '0;
            vld_p0    <= 1'b0;
        end else begin
            valid_q <= valid;
            vld_p0  <= new_sample;
            if (new_sample) begin
                captured  <= 1'b1;
                last_pair <= {humidity, temperature};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (new_sample) pair_p0 <= {humidity, temperature};
    end

    // A waiting reading always wins over a fresh one when a frame can start.
    assign take_slot = (state == IDLE) && pending;
    assign take_new  = (state == IDLE) && !pending && vld_p0;
    assign to_slot   = vld_p0 && !take_new;
    assign conv_last = (state == CONVERT) && conv_temp && (rem < 8'd10);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pending    <= 1'b0;
            drop_count <= '0;
            idx        <= '0;
        end else begin
            state <= state_nx;
            if (to_slot) begin
                pending <= 1'b1;
                if (pending && !take_slot) drop_count <= sat_inc(drop_count);
            end else if (take_slot) begin
                pending <= 1'b0;
            end
            if (state == IDLE) begin
                idx <= '0;
            end else if ((state == SEND) && tx_done && (idx != LAST_IDX)) begin
                idx <= idx + 4'd1;
            end
        end
    end

    // Frame latch and digit conversion: subtract 100s, then 10s, remainder is the ones digit.
    always_ff @(posedge clk) begin
        if (to_slot) slot <= pair_p0;
        if (take_slot) begin
            frame_pair <= slot;
        end else if (take_new) begin
            frame_pair <= pair_p0;
        end
        if (take_slot || take_new) begin
            rem       <= take_slot ? slot[15:8] : pair_p0[15:8];
            conv_temp <= 1'b0;
            hun       <= '0;
            ten       <= '0;
        end else if (state == CONVERT) begin
            if (rem >= 8'd100) begin
                rem <= rem - 8'd100;
                hun <= hun + 4'd1;
            end else if (rem >= 8'd10) begin
                rem <= rem - 8'd10;
                ten <= ten + 4'd1;
            end else begin
                if (!conv_temp) hum_bcd <= {hun, ten, rem[3:0]};
                else            tmp_bcd <= {hun, ten, rem[3:0]};
                conv_temp <= 1'b1;
                rem       <= frame_pair[7:0];
                hun       <= '0;
                ten       <= '0;
            end
        end
    end

    always_comb begin
        tx_byte = ASC_SP;
        case (idx)
            4'd0:    tx_byte = ASC_H;
            4'd1:    tx_byte = ASC_EQ;
            4'd2:    tx_byte = ascii_digit(hum_bcd[11:8]);
            4'd3:    tx_byte = ascii_digit(hum_bcd[7:4]);
            4'd4:    tx_byte = ascii_digit(hum_bcd[3:0]);
            4'd5:    tx_byte = ASC_SP;
            4'd6:    tx_byte = ASC_T;
            4'd7:    tx_byte = ASC_EQ;
            4'd8:    tx_byte = ascii_digit(tmp_bcd[11:8]);
            4'd9:    tx_byte = ascii_digit(tmp_bcd[7:4]);
            4'd10:   tx_byte = ascii_digit(tmp_bcd[3:0]);
            4'd11:   tx_byte = ASC_CR;
            4'd12:   tx_byte = ASC_LF;
            default: tx_byte = ASC_SP;
        endcase
    end

    always_comb begin
        state_nx = state;
        tx_start = 1'b0;
        case (state)
            IDLE:    if (pending || vld_p0) state_nx = CONVERT;
            CONVERT: if (conv_last) state_nx = LOAD;
            LOAD: begin
                tx_start = tx_ready;
                if (tx_ready) state_nx = SEND;
            end
            SEND:    if (tx_done) state_nx = (idx == LAST_IDX) ? IDLE : LOAD;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    uart_tx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk  (clk),
        .reset(reset),
        .start(tx_start),
        .data (tx_byte),
        .tx   (tx),
        .ready(tx_ready),
        .done (tx_done)
    );

endmodule

// File: tb/tb_dht_uart_reporter.sv
// Randomized self-checking bench: UART line decoder plus a frame-level reference model.
module tb_dht_uart_reporter;
    localparam int CPB       = 8;
    localparam int FRAME_CYC = 13 * (10 * CPB + 2);

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] humidity, temperature;
    logic       valid;
    logic       tx, busy, pending;
    logic [7:0] drop_count;

    dht_uart_reporter #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .humidity   (humidity),
        .temperature(temperature),
        .valid      (valid),
        .tx         (tx),
        .busy       (busy),
        .pending    (pending),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Line decoder: samples every negedge, one byte = 80 samples.
    logic [7:0] rx_q[$];
    int         rx_start[$];
    bit         rx_busy[$];
    int         width_bad = 0;
    int         gap_bad = 0;
    int         idle_run = 1000;

    initial begin : uart_monitor
        logic [79:0] samp;
        logic [7:0]  b;
        bit          ok, aborted, busy_end;
        int          s_cyc;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                idle_run = 1000;
            end else if (tx === 1'b0) begin
                if (idle_run >= 3 && idle_run <= 4) gap_bad++;
                s_cyc = cyc; samp = '0; aborted = 0; busy_end = 0;
                for (int n = 1; n < 80; n++) begin
                    @(negedge clk);
                    if (reset === 1'b1) begin aborted = 1; break; end
                    samp[n] = tx;
                    busy_end = busy;
                end
                if (aborted) begin
                    idle_run = 1000;
                end else begin
                    ok = (samp[72] === 1'b1);
                    for (int bb = 0; bb < 10; bb++)
                        for (int k = 1; k < 8; k++)
                            if (samp[bb*8+k] !== samp[bb*8]) ok = 0;
                    for (int i = 0; i < 8; i++) b[i] = samp[8*(i+1)];
                    if (!ok) width_bad++;
                    rx_q.push_back(b);
                    rx_start.push_back(s_cyc);
                    rx_busy.push_back(busy_end);
                    idle_run = 0;
                end
            end else begin
                idle_run++;
            end
        end
    end

    // Reference model: expected frames as text, plus pending slot and drop counter.
    logic [103:0] exp_q[$];
    int           rd_ptr = 0;
    bit           m_valid, m_capt, m_busy, m_pend;
    logic [15:0]  m_last, m_slot;
    int           m_drop;
    int           last_ev_cyc;

    function automatic logic [103:0] frame_of(input logic [7:0] h, input logic [7:0] t);
        string        s;
        logic [103:0] v;
        v = '0;
        s = $sformatf("H=%03d T=%03d", h, t);
        for (int i = 0; i < 11; i++) v = {v[95:0], s[i]};
        v = {v[87:0], 8'h0D, 8'h0A};
        return v;
    endfunction

    task automatic apply(input bit v, input logic [7:0] h, input logic [7:0] t);
        bit ev;
        @(negedge clk);
        valid = v; humidity = h; temperature = t;
        last_ev_cyc = cyc + 1;
        ev = v && (!m_valid || !m_capt || ({h, t} != m_last));
        if (ev) begin
            m_last = {h, t};
            m_capt = 1;
            if (!m_busy) begin
                m_busy = 1;
                exp_q.push_back(frame_of(h, t));
            end else begin
                if (m_pend) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                m_slot = {h, t};
                m_pend = 1;
            end
        end
        m_valid = v;
    endtask

    task automatic wait_bytes(input int n);
        int t0;
        t0 = cyc;
        while (rx_q.size() < n && cyc - t0 < 4 * FRAME_CYC) @(negedge clk);
        if (rx_q.size() < n) chk("wait_bytes_timeout", 128'(rx_q.size()), 128'(n));
    endtask

    task automatic expect_frame(input string tag, input bit chk_lat, input int ev_cyc);
        int           t0;
        logic [103:0] got, want;
        t0 = cyc;
        while (rx_q.size() < rd_ptr + 13 && cyc - t0 < 3 * FRAME_CYC) @(negedge clk);
        if (rx_q.size() < rd_ptr + 13) begin
            chk({tag, "_timeout"}, 128'(rx_q.size()), 128'(rd_ptr + 13));
            rd_ptr = rx_q.size();
            return;
        end
        got = '0;
        for (int i = 0; i < 13; i++) got = {got[95:0], rx_q[rd_ptr+i]};
        want = '0;
        if (exp_q.size() > 0) want = exp_q.pop_front();
        chk({tag, "_bytes"}, 128'(got), 128'(want));
        if (chk_lat) chk({tag, "_latency_le32"}, 128'((rx_start[rd_ptr] - ev_cyc) <= 32), 128'(1));
        chk({tag, "_duration"}, 128'((rx_start[rd_ptr+12] + 80 - rx_start[rd_ptr]) <= FRAME_CYC), 128'(1));
        chk({tag, "_busy_in_stop"}, 128'(rx_busy[rd_ptr+12]), 128'(1));
        rd_ptr += 13;
        if (m_pend) begin
            exp_q.push_back(frame_of(m_slot[15:8], m_slot[7:0]));
            m_pend = 0;
        end else begin
            m_busy = 0;
            repeat (3) @(negedge clk);
            chk({tag, "_busy_fell"}, 128'(busy), 128'(0));
        end
    endtask

    initial begin : watchdog
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int         ev, n0, k;
        logic [7:0] h, t;
        reset = 1'b1; valid = 1'b0; humidity = '0; temperature = '0;
        m_valid = 0; m_capt = 0; m_busy = 0; m_pend = 0; m_last = '0; m_slot = '0; m_drop = 0;

        repeat (3) @(negedge clk);
        chk("rst_tx", 128'(tx), 128'(1));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_pending", 128'(pending), 128'(0));
        chk("rst_drop", 128'(drop_count), 128'(0));
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_tx", 128'(tx), 128'(1));

        apply(1, 8'd72, 8'd25); ev = last_ev_cyc;
        expect_frame("f72_25", 1, ev);

        apply(1, 8'd255, 8'd0); ev = last_ev_cyc;
        expect_frame("f255_0", 1, ev);
        apply(1, 8'd0, 8'd9); ev = last_ev_cyc;
        expect_frame("f0_9", 1, ev);

        apply(1, 8'd40, 8'd20); ev = last_ev_cyc;
        expect_frame("f40_20", 1, ev);
        n0 = rx_q.size();
        repeat (5 * FRAME_CYC) @(negedge clk);
        chk("hold_one_frame", 128'(rx_q.size()), 128'(n0));
        chk("hold_drop", 128'(drop_count), 128'(m_drop));

        apply(1, 8'd10, 8'd11); ev = last_ev_cyc;
        wait_bytes(rd_ptr + 1);
        apply(1, 8'd50, 8'd21);
        apply(1, 8'd51, 8'd22);
        repeat (2) @(negedge clk);
        chk("ovw_pending", 128'(pending), 128'(m_pend));
        chk("ovw_drop", 128'(drop_count), 128'(m_drop));
        expect_frame("f10_11", 1, ev);
        wait_bytes(rd_ptr + 1);
        for (int i = 0; i <= 300; i++) apply(1, 8'(i), 8'd200);
        repeat (2) @(negedge clk);
        chk("sat_drop", 128'(drop_count), 128'(m_drop));
        chk("sat_pending", 128'(pending), 128'(m_pend));
        expect_frame("f51_22", 0, 0);
        expect_frame("f_last_overwrite", 0, 0);

        apply(1, 8'd60, 8'd61);
        wait_bytes(rd_ptr + 1);
        apply(1, 8'd62, 8'd63);
        apply(1, 8'd64, 8'd65);
        wait_bytes(rd_ptr + 3);
        repeat (20) @(negedge clk);
        reset = 1'b1; valid = 1'b0;
        @(negedge clk);
        chk("midrst_tx", 128'(tx), 128'(1));
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_pending", 128'(pending), 128'(0));
        chk("midrst_drop", 128'(drop_count), 128'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        m_valid = 0; m_capt = 0; m_busy = 0; m_pend = 0; m_last = '0; m_drop = 0;
        repeat (5) @(negedge clk);
        rd_ptr = rx_q.size();
        chk("postrst_busy", 128'(busy), 128'(0));
        apply(1, 8'd33, 8'd44); ev = last_ev_cyc;
        expect_frame("f_after_reset", 1, ev);

        for (int it = 0; it < 6; it++) begin
            h = 8'($urandom_range(0, 255));
            t = 8'($urandom_range(0, 255));
            if ({h, t} == m_last) h = h + 8'd1;
            apply(1, h, t); ev = last_ev_cyc;
            if ($urandom_range(0, 1) == 1) begin
                wait_bytes(rd_ptr + 1 + int'($urandom_range(0, 8)));
                k = int'($urandom_range(1, 4));
                for (int j = 0; j < k; j++)
                    apply(1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            end
            repeat (2) @(negedge clk);
            chk("rnd_pending", 128'(pending), 128'(m_pend));
            chk("rnd_drop", 128'(drop_count), 128'(m_drop));
            expect_frame("rnd", 1, ev);
            if (exp_q.size() > 0) expect_frame("rnd_pend", 0, 0);
        end

        chk("bit_timing", 128'(width_bad), 128'(0));
        chk("inter_byte_gap", 128'(gap_bad), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
